// File: rtl/seq_pattern_tx.sv
// Serial pattern burst transmitter. Sends PATTERN (MSB first) rep_cnt times,
// with gap zero-bits between repetitions, then pulses done.
module seq_pattern_tx #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
  parameter int                 CNT_W   = 4,
  parameter int                 GAP_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, FIN} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [GAP_W-1:0] gcnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] rep_q;
  logic [CNT_W-1:0] pat_cnt_q;
  logic             out_q;
  logic             vld_q;
  logic             done_q;

  // Outputs are registered for the cycle being entered; idx_q names the bit
  // currently on out while in SHIFT, gcnt_q the gap bits still to follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gcnt_q    <= '0;
      gap_q     <= '0;
      rep_q     <= '0;
      pat_cnt_q <= '0;
      out_q     <= 1'b0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      out_q  <= 1'b0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            rep_q     <= rep_cnt;
            gap_q     <= gap;
            pat_cnt_q <= '0;
            idx_q     <= IDX_TOP;
            gcnt_q    <= '0;
            if (rep_cnt != '0) begin
              state_q <= SHIFT;
              out_q   <= PATTERN[PAT_W-1];
              vld_q   <= 1'b1;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (idx_q == '0) begin
            pat_cnt_q <= CNT_W'(pat_cnt_q + 1'b1);
            if (CNT_W'(pat_cnt_q + 1'b1) == rep_q) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else if (gap_q != '0) begin
              state_q <= GAP;
              gcnt_q  <= GAP_W'(gap_q - 1'b1);
              vld_q   <= 1'b1;
            end else begin
              idx_q <= IDX_TOP;
              out_q <= PATTERN[PAT_W-1];
              vld_q <= 1'b1;
            end
          end else begin
            idx_q <= IDX_W'(idx_q - 1'b1);
            out_q <= PATTERN[IDX_W'(idx_q - 1'b1)];
            vld_q <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (gcnt_q == '0) begin
            state_q <= SHIFT;
            idx_q   <= IDX_TOP;
            out_q   <= PATTERN[PAT_W-1];
            vld_q   <= 1'b1;
          end else begin
            gcnt_q <= GAP_W'(gcnt_q - 1'b1);
            vld_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pat_cnt   = pat_cnt_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx with default parameters.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] rep_cnt;
  logic [2:0] gap;
  logic       out, out_valid, busy, done;
  logic [3:0] pat_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] c_stream;
  int          c_n, c_det, c_bad, c_breaks;
  bit          c_done;

  seq_pattern_tx dut (
    .clk(clk), .rst(rst), .start(start), .rep_cnt(rep_cnt), .gap(gap),
    .abort(abort), .out(out), .out_valid(out_valid), .busy(busy),
    .done(done), .pat_cnt(pat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] r, input logic [2:0] g);
    rep_cnt = r;
    gap     = g;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Gathers valid bits until done (bounded), running a 1011 detector on them.
  task automatic collect(input int maxcyc);
    logic [3:0] sh;
    bit started;
    sh = '0; started = 0;
    c_stream = '0; c_n = 0; c_det = 0; c_bad = 0; c_breaks = 0; c_done = 0;
    for (int i = 0; i < maxcyc; i++) begin
      if (done) begin
        c_done = 1;
        break;
      end
      if (out_valid) begin
        started  = 1;
        c_stream = {c_stream[62:0], out};
        c_n++;
        sh = {sh[2:0], out};
        if (c_n >= 4 && sh == 4'b1011) c_det++;
      end else begin
        if (out !== 1'b0) c_bad++;
        if (started) c_breaks++;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; abort = 1'b0; rep_cnt = 4'd3; gap = 3'd0;
    tick(); tick();
    start = 1'b0;
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pat_cnt !== 4'd0) begin errors++; $display("FAIL reset_patcnt got %0d want 0", pat_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic single_burst_checks(input string tag);
    logic [3:0] exp;
    exp = 4'b1011;
    launch(4'd1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out !== exp[3-i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL %s_bit%0d got out=%b vld=%b busy=%b done=%b want out=%b vld=1 busy=1 done=0",
                           tag, i, out, out_valid, busy, done, exp[3-i]);
      end
      tick();
    end
    checks++; if (done !== 1'b1 || out_valid !== 1'b0 || out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_fin got done=%b vld=%b out=%b busy=%b want 1 0 0 1", tag, done, out_valid, out, busy);
    end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pat_cnt !== 4'd1) begin
      errors++; $display("FAIL %s_idle got busy=%b done=%b pat_cnt=%0d want 0 0 1", tag, busy, done, pat_cnt);
    end
  endtask

  task automatic test_single;
    single_burst_checks("single");
  endtask

  task automatic test_back_to_back;
    launch(4'd3, 3'd0);
    collect(40);
    checks++; if (c_n != 12 || c_stream[11:0] !== 12'b101110111011) begin
      errors++; $display("FAIL b2b_stream got n=%0d bits=%b want n=12 bits=101110111011", c_n, c_stream[11:0]);
    end
    checks++; if (c_det != 3) begin errors++; $display("FAIL b2b_detect got %0d want 3", c_det); end
    checks++; if (!c_done || c_breaks != 0 || c_bad != 0) begin
      errors++; $display("FAIL b2b_contig got done=%0d breaks=%0d bad=%0d want 1 0 0", c_done, c_breaks, c_bad);
    end
    checks++; if (pat_cnt !== 4'd3) begin errors++; $display("FAIL b2b_patcnt got %0d want 3", pat_cnt); end
    tick(); tick();
  endtask

  task automatic test_gap;
    launch(4'd2, 3'd2);
    collect(40);
    checks++; if (c_n != 10 || c_stream[9:0] !== 10'b1011001011) begin
      errors++; $display("FAIL gap_stream got n=%0d bits=%b want n=10 bits=1011001011", c_n, c_stream[9:0]);
    end
    checks++; if (!c_done || pat_cnt !== 4'd2) begin
      errors++; $display("FAIL gap_done got done=%0d pat_cnt=%0d want 1 2", c_done, pat_cnt);
    end
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_after got busy=%b vld=%b want 0 0", busy, out_valid);
    end
    tick();
  endtask

  task automatic test_zero;
    launch(4'd0, 3'd3);
    checks++; if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || pat_cnt !== 4'd0) begin
      errors++; $display("FAIL zero_fin got done=%b busy=%b vld=%b pat_cnt=%0d want 1 1 0 0", done, busy, out_valid, pat_cnt);
    end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_idle got done=%b busy=%b vld=%b want 0 0 0", done, busy, out_valid);
    end
    tick();
  endtask

  task automatic test_max;
    launch(4'd15, 3'd0);
    collect(100);
    checks++; if (c_n != 60 || c_det != 15 || !c_done) begin
      errors++; $display("FAIL max_count got n=%0d det=%0d done=%0d want 60 15 1", c_n, c_det, c_done);
    end
    checks++; if (pat_cnt !== 4'd15) begin errors++; $display("FAIL max_patcnt got %0d want 15", pat_cnt); end
    tick(); tick();
  endtask

  task automatic test_ignore_abort;
    launch(4'd2, 3'd1);
    rep_cnt = 4'd5; gap = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (out_valid !== 1'b1 || out !== 1'b0) begin
      errors++; $display("FAIL restart_bit1 got vld=%b out=%b want 1 0", out_valid, out);
    end
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b1 || out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_gapbit got vld=%b out=%b busy=%b want 1 0 1", out_valid, out, busy);
    end
    tick();
    checks++; if (out_valid !== 1'b1 || out !== 1'b1 || pat_cnt !== 4'd1) begin
      errors++; $display("FAIL pat2_first got vld=%b out=%b pat_cnt=%0d want 1 1 1", out_valid, out, pat_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (out_valid !== 1'b0 || out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pat_cnt !== 4'd1) begin
      errors++; $display("FAIL abort got vld=%b out=%b busy=%b done=%b pat_cnt=%0d want 0 0 0 0 1",
                         out_valid, out, busy, done, pat_cnt);
    end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_nodone got done=%b busy=%b want 0 0", done, busy);
    end
    rep_cnt = 4'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || pat_cnt !== 4'd1) begin
      errors++; $display("FAIL abort_wins got busy=%b vld=%b pat_cnt=%0d want 0 0 1", busy, out_valid, pat_cnt);
    end
    tick();
  endtask

  task automatic test_rst_mid;
    launch(4'd2, 3'd3);
    tick(); tick(); tick(); tick();
    checks++; if (out_valid !== 1'b1 || out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_ingap got vld=%b out=%b busy=%b want 1 0 1", out_valid, out, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pat_cnt !== 4'd0) begin
      errors++; $display("FAIL rstmid_reset got vld=%b out=%b busy=%b done=%b pat_cnt=%0d want 0 0 0 0 0",
                         out_valid, out, busy, done, pat_cnt);
    end
    tick();
    single_burst_checks("after_rst");
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rep_cnt = '0; gap = '0;
    test_reset();
    test_single();
    tick();
    test_back_to_back();
    test_gap();
    test_zero();
    test_max();
    test_ignore_abort();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got still running want finished");
    $fatal(1, "timeout");
  end

endmodule
